// File: rtl/seg_readback.sv
// Seven-segment readback decoder: filters {an, seg} for stability, decodes each
// committed pattern back to a BCD digit per position, and flags protocol errors.
module seg_readback #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_done,
    output logic                      err
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);

    // Decode result packed as {valid, bad_pattern, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h40:   r = {1'b1, 1'b0, 4'h0};
            7'h79:   r = {1'b1, 1'b0, 4'h1};
            7'h24:   r = {1'b1, 1'b0, 4'h2};
            7'h30:   r = {1'b1, 1'b0, 4'h3};
            7'h19:   r = {1'b1, 1'b0, 4'h4};
            7'h12:   r = {1'b1, 1'b0, 4'h5};
            7'h02:   r = {1'b1, 1'b0, 4'h6};
            7'h78:   r = {1'b1, 1'b0, 4'h7};
            7'h00:   r = {1'b1, 1'b0, 4'h8};
            7'h10:   r = {1'b1, 1'b0, 4'h9};
            7'h7F:   r = {1'b0, 1'b0, 4'hF};
            default: r = {1'b0, 1'b1, 4'hE};
        endcase
        return r;
    endfunction

    logic [SW-1:0]             r_s_q;
    logic [CW-1:0]             r_cnt;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_valid;
    logic                      r_frame;
    logic                      r_err;

    logic                      w_same;
    logic                      w_commit;
    logic [5:0]                w_dec;
    logic [NUM_DIGITS-1:0]     w_an_low;
    logic                      w_single;
    logic                      w_multi;
    logic [CW-1:0]             w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   w_digits_nxt;
    logic [NUM_DIGITS-1:0]     w_valid_nxt;
    logic [NUM_DIGITS-1:0]     w_seen_nxt;
    logic                      w_frame_nxt;
    logic                      w_err_set;
    logic                      w_err_nxt;

    // Stability filter, commit decision and per-position update.
    always_comb begin
        w_same       = ({an, seg} == r_s_q);
        w_commit     = w_same && (r_cnt == CNT_COMMIT);
        w_dec        = decode_seg(r_s_q[6:0]);
        w_an_low     = ~r_s_q[SW-1:7];
        w_single     = (w_an_low != '0) &&
                       ((w_an_low & (w_an_low - NUM_DIGITS'(1))) == '0);
        w_multi      = (w_an_low != '0) && !w_single;
        w_digits_nxt = r_digits;
        w_valid_nxt  = r_valid;
        w_seen_nxt   = r_seen;
        w_frame_nxt  = 1'b0;
        w_err_set    = 1'b0;

        if (!w_same) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end

        if (w_commit && w_single) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_digits_nxt[4*i +: 4] = w_an_low[i] ? w_dec[3:0] : r_digits[4*i +: 4];
                w_valid_nxt[i]         = w_an_low[i] ? w_dec[5]   : r_valid[i];
            end
            w_seen_nxt = r_seen | w_an_low;
            w_err_set  = w_dec[4];
            if (&w_seen_nxt) begin
                w_frame_nxt = 1'b1;
                w_seen_nxt  = '0;
            end else begin
                w_frame_nxt = 1'b0;
            end
        end else if (w_commit) begin
            // All anodes high is a legal blanked display; only overlap is an error.
            w_err_set = w_multi;
        end else begin
            w_err_set = 1'b0;
        end

        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (clear) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q    <= '1;
            r_cnt    <= CNT_MAX;
            r_seen   <= '0;
            r_digits <= {NUM_DIGITS{4'hF}};
            r_valid  <= '0;
            r_frame  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_s_q    <= {an, seg};
            r_cnt    <= w_cnt_nxt;
            r_seen   <= w_seen_nxt;
            r_digits <= w_digits_nxt;
            r_valid  <= w_valid_nxt;
            r_frame  <= w_frame_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame;
    assign err         = r_err;

endmodule

// File: tb/tb_seg_readback.sv
// Scoreboard bench for seg_readback: expected output snapshots are queued with
// the cycle at which they must appear and compared as the clock advances.
module tb_seg_readback;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;

    seg_readback #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clear(clear),
        .digits(digits), .digit_valid(digit_valid),
        .frame_done(frame_done), .err(err)
    );

    typedef struct {
        int          at;
        logic [15:0] d;
        logic [3:0]  v;
        logic        e;
        logic        f;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    int          cyc;
    int          frames;
    logic [15:0] exp_d;
    logic [3:0]  exp_v;
    logic        exp_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) frames <= frames + 1;
    end

    task automatic push(input int at, input logic f, input string tag);
        sb.push_back('{at, exp_d, exp_v, exp_e, f, tag});
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            x = sb.pop_front();
            vectors++;
            if (x.at != cyc || digits !== x.d || digit_valid !== x.v ||
                err !== x.e || frame_done !== x.f) begin
                miscompares++;
                $display("FAIL %s @%0d (due %0d): got digits=%h valid=%b err=%b fd=%b, want %h %b %b %b",
                         x.tag, cyc, x.at, digits, digit_valid, err, frame_done,
                         x.d, x.v, x.e, x.f);
            end
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) tick();
    endtask

    // Hold one position for 8 cycles; expects the commit 4 edges after first sample.
    task automatic commit_pos(input int p, input logic [6:0] s, input logic [3:0] nib,
                              input logic v, input logic e_set, input logic fr,
                              input string tag);
        int         c;
        logic [3:0] a;
        c = cyc;
        a = ~(4'b0001 << p);
        push(c + 4, 1'b0, {tag, "_pre"});
        exp_d[4*p +: 4] = nib;
        exp_v[p]        = v;
        if (e_set) exp_e = 1'b1;
        push(c + 5, fr, tag);
        push(c + 6, 1'b0, {tag, "_post"});
        drive(a, s, 8);
    endtask

    task automatic clear_err(input string tag);
        drive(4'hF, 7'h7F, 4);
        clear = 1'b1;
        exp_e = 1'b0;
        push(cyc + 1, 1'b0, tag);
        tick();
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (digits !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL %s digits: got %h want ffff", tag, digits);
        end
        vectors++;
        if (digit_valid !== 4'h0) begin
            miscompares++;
            $display("FAIL %s valid: got %b want 0000", tag, digit_valid);
        end
        vectors++;
        if (frame_done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s fd/err: got %b/%b want 0/0", tag, frame_done, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        clear = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_d = 16'hFFFF;
        exp_v = 4'h0;
        exp_e = 1'b0;
        push(cyc + 10, 1'b0, "idle10");
        push(cyc + 30, 1'b0, "idle30");
        push(cyc + 50, 1'b0, "idle50");
        drive(4'hF, 7'h7F, 50);
        vectors++;
        if (frames !== 0) begin
            miscompares++;
            $display("FAIL idle_frames: got %0d want 0", frames);
        end
    endtask

    task automatic test_scan();
        int f0;
        f0 = frames;
        commit_pos(0, 7'h40, 4'h0, 1'b1, 1'b0, 1'b0, "scan0");
        commit_pos(1, 7'h79, 4'h1, 1'b1, 1'b0, 1'b0, "scan1");
        commit_pos(2, 7'h24, 4'h2, 1'b1, 1'b0, 1'b0, "scan2");
        commit_pos(3, 7'h30, 4'h3, 1'b1, 1'b0, 1'b1, "scan3");
        vectors++;
        if (frames - f0 !== 1 || digits !== 16'h3210) begin
            miscompares++;
            $display("FAIL scan_frame: got frames=%0d digits=%h want 1 3210", frames - f0, digits);
        end
    endtask

    task automatic test_filter();
        int c;
        c = cyc;
        push(c + 3, 1'b0, "short_12");
        push(c + 7, 1'b0, "pre_02");
        exp_d[7:4] = 4'h6;
        push(c + 8, 1'b0, "commit_02");
        drive(4'b1101, 7'h12, 3);
        drive(4'b1101, 7'h02, 6);
    endtask

    task automatic test_pattern_err();
        int c;
        commit_pos(2, 7'h55, 4'hE, 1'b0, 1'b1, 1'b0, "bad_seg");
        clear_err("clear_quiet");
        c = cyc;
        push(c + 4, 1'b0, "bad_again_pre");
        drive(4'b1011, 7'h55, 4);
        clear = 1'b1;
        exp_e = 1'b1;
        push(c + 5, 1'b0, "set_beats_clear");
        tick();
        clear = 1'b0;
        drive(4'b1011, 7'h55, 2);
        clear_err("clear_after");
    endtask

    task automatic test_multi_anode();
        int c;
        int f0;
        c = cyc;
        push(c + 4, 1'b0, "multi_pre");
        exp_e = 1'b1;
        push(c + 5, 1'b0, "multi");
        push(c + 10, 1'b0, "multi_hold");
        drive(4'b1100, 7'h40, 10);
        clear_err("clear_multi");
        f0 = frames;
        commit_pos(0, 7'h78, 4'h7, 1'b1, 1'b0, 1'b0, "ovl0");
        commit_pos(1, 7'h00, 4'h8, 1'b1, 1'b0, 1'b0, "ovl1");
        drive(4'b1100, 7'h00, 2);
        commit_pos(2, 7'h10, 4'h9, 1'b1, 1'b0, 1'b0, "ovl2");
        commit_pos(3, 7'h40, 4'h0, 1'b1, 1'b0, 1'b1, "ovl3");
        vectors++;
        if (frames - f0 !== 1) begin
            miscompares++;
            $display("FAIL ovl_frames: got %0d want 1", frames - f0);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        commit_pos(0, 7'h40, 4'h0, 1'b1, 1'b0, 1'b0, "pre_rst0");
        commit_pos(1, 7'h79, 4'h1, 1'b1, 1'b0, 1'b0, "pre_rst1");
        drive(4'b1011, 7'h24, 2);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        an    = 4'hF;
        seg   = 7'h7F;
        exp_d = 16'hFFFF;
        exp_v = 4'h0;
        exp_e = 1'b0;
        tick();
        rst_n = 1'b1;
        f0 = frames;
        commit_pos(2, 7'h24, 4'h2, 1'b1, 1'b0, 1'b0, "post_rst2");
        commit_pos(3, 7'h30, 4'h3, 1'b1, 1'b0, 1'b0, "post_rst3");
        commit_pos(0, 7'h40, 4'h0, 1'b1, 1'b0, 1'b0, "post_rst0");
        commit_pos(1, 7'h79, 4'h1, 1'b1, 1'b0, 1'b1, "post_rst1");
        vectors++;
        if (frames - f0 !== 1) begin
            miscompares++;
            $display("FAIL post_rst_frames: got %0d want 1", frames - f0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        frames      = 0;
        test_reset();
        test_scan();
        test_filter();
        test_pattern_err();
        test_multi_anode();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
